// File: rtl/stream_pool_unit.sv
// Streaming P x P non-overlapping pooling stage (MAX or AVERAGE) for the CNN datapath.
// Raster-order pixels in, one pooled pixel per completed window out over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for start; no input accepted
// ST_RUN   | accepting pixels and pooling windows
// ST_DRAIN | all pixels taken, waiting for the output register to empty
module stream_pool_unit #(
  parameter int IN_WIDTH     = 10,
  parameter int IN_HEIGHT    = 10,
  parameter int NUM_FEATURES = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int POOL_SIZE    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_cnn,
  input  logic                                 start,
  input  logic                                 mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]   in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]   out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int LOG_P      = (POOL_SIZE == 4) ? 2 : 1;
  localparam int ACC_W      = DATA_WIDTH + 2 * LOG_P;
  localparam int OUT_WIDTH  = IN_WIDTH / POOL_SIZE;
  localparam int OUT_HEIGHT = IN_HEIGHT / POOL_SIZE;
  localparam int COL_W      = $clog2(IN_WIDTH + 1);
  localparam int ROW_W      = $clog2(IN_HEIGHT + 1);
  localparam int BUS_W      = NUM_FEATURES * DATA_WIDTH;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IN_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_KEEP     = COL_W'(OUT_WIDTH * POOL_SIZE);
  localparam logic [ROW_W-1:0] ROW_KEEP     = ROW_W'(OUT_HEIGHT * POOL_SIZE);
  localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'(OUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'(OUT_HEIGHT - 1);

  generate
    if (POOL_SIZE != 2 && POOL_SIZE != 4) begin : g_bad_pool
      $error("stream_pool_unit: POOL_SIZE must be 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic                      mode_q, mode_d;
  logic signed [ACC_W-1:0]   acc_q [OUT_WIDTH][NUM_FEATURES];
  logic signed [ACC_W-1:0]   acc_d [OUT_WIDTH][NUM_FEATURES];
  logic                      out_valid_q, out_valid_d;
  logic [BUS_W-1:0]          out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;

  logic                      accept;
  logic                      out_fire;
  logic                      in_keep;
  logic                      win_first;
  logic                      win_last;
  logic                      win_done;
  logic                      frame_end_px;
  logic [COL_W-1:0]          win_col;
  logic [ROW_W-1:0]          win_row;
  logic signed [ACC_W-1:0]   px_ext [NUM_FEATURES];
  logic signed [ACC_W-1:0]   cur    [NUM_FEATURES];
  logic signed [ACC_W-1:0]   upd    [NUM_FEATURES];
  logic [BUS_W-1:0]          result;

  assign out_fire     = out_valid_q && out_ready;
  assign in_ready     = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept       = in_valid && in_ready;
  assign win_col      = col_q >> LOG_P;
  assign win_row      = row_q >> LOG_P;
  assign in_keep      = (col_q < COL_KEEP) && (row_q < ROW_KEEP);
  assign win_first    = (col_q[LOG_P-1:0] == '0) && (row_q[LOG_P-1:0] == '0);
  assign win_last     = (&col_q[LOG_P-1:0]) && (&row_q[LOG_P-1:0]);
  assign win_done     = accept && in_keep && win_last;
  assign frame_end_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Per-channel datapath: sign-extend the pixel, fetch its column entry, fold it in.
  always_comb begin
    result = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      px_ext[f] = {{(ACC_W-DATA_WIDTH){in_data[f*DATA_WIDTH+DATA_WIDTH-1]}},
                   in_data[f*DATA_WIDTH +: DATA_WIDTH]};
      cur[f] = '0;
      for (int e = 0; e < OUT_WIDTH; e++) begin
        if (win_col == COL_W'(e)) begin
          cur[f] = acc_q[e][f];
        end
      end
      if (win_first) begin
        upd[f] = px_ext[f];
      end else if (mode_q) begin
        upd[f] = cur[f] + px_ext[f];
      end else begin
        upd[f] = (px_ext[f] > cur[f]) ? px_ext[f] : cur[f];
      end
      // The window sum divided by P*P always lands back inside DATA_WIDTH.
      result[f*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(mode_q ? (upd[f] >>> (2 * LOG_P)) : upd[f]);
    end
  end

  always_comb begin
    for (int e = 0; e < OUT_WIDTH; e++) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        acc_d[e][f] = acc_q[e][f];
        if (accept && in_keep && (win_col == COL_W'(e))) begin
          acc_d[e][f] = upd[f];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    // A load may coincide with the handshake above, keeping one beat per cycle.
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_last_d  = (win_row == WIN_ROW_LAST) && (win_col == WIN_COL_LAST);
    end

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept && frame_end_px) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_fire) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int e = 0; e < OUT_WIDTH; e++) begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
          acc_q[e][f] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      for (int e = 0; e < OUT_WIDTH; e++) begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
          acc_q[e][f] <= acc_d[e][f];
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
